// File: rtl/ps2_byte_receiver.sv
// rtl/ps2_byte_receiver.sv - PS/2 device-to-host byte receiver with parity/stop checking and inter-edge timeout
module ps2_byte_receiver #(
    parameter int TIMEOUT = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic clk_meta_q, clk_meta_d;
    logic clk_s_q, clk_s_d;
    logic clk_d_q, clk_d_d;
    logic dat_meta_q, dat_meta_d;
    logic dat_s_q, dat_s_d;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    err_q, err_d;
    logic          ready_q, ready_d;

    logic fall;
    logic timed_out;

    always_comb begin
        clk_meta_d = CLK_MOUSE_IN;
        clk_s_d    = clk_meta_q;
        clk_d_d    = clk_s_q;
        dat_meta_d = DATA_MOUSE_IN;
        dat_s_d    = dat_meta_q;
    end

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_meta_q <= 1'b1;
            clk_s_q    <= 1'b1;
            clk_d_q    <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_s_q    <= 1'b1;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_s_q    <= clk_s_d;
            clk_d_q    <= clk_d_d;
            dat_meta_q <= dat_meta_d;
            dat_s_q    <= dat_s_d;
        end
    end

    assign fall      = clk_d_q & ~clk_s_q;
    assign timed_out = (to_cnt_q == TO_MAX);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = to_cnt_q;
        byte_d    = byte_q;
        err_d     = err_q;
        ready_d   = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (!timed_out) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s_q && READ_ENABLE) begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = dat_s_q;
                    state_d  = ST_STOP;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                // Errors are reported alongside the byte, never used to drop it.
                if (fall) begin
                    byte_d  = shift_q;
                    err_d   = {~dat_s_q, ~(^{shift_q, parity_q})};
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            byte_q    <= '0;
            err_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = ready_q;

endmodule

// File: doc/ps2_byte_receiver.md
# ps2_byte_receiver

Receives PS/2 device-to-host frames from the mouse, one byte at a time, and hands each byte to the mouse master state machine. It sits between the synchronised PS/2 pins and the master state machine. It drives that block's `BYTE_READ`, `BYTE_ERROR_CODE` and `BYTE_READY` inputs and obeys its `READ_ENABLE` output. Host-to-device transmission is handled by a separate transmitter block; this block never drives the PS/2 lines.

## Interface
- `TIMEOUT`, default 50000: maximum CLK cycles allowed between consecutive PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- `CLK` input 1: system clock, 50 MHz.
- `RESET` input 1: asynchronous, active-high reset.
- `CLK_MOUSE_IN` input 1: raw PS/2 clock line (asynchronous).
- `DATA_MOUSE_IN` input 1: raw PS/2 data line (asynchronous).
- `READ_ENABLE` input 1: high permits a new frame to start.
- `BYTE_READ` output 8: last received data byte.
- `BYTE_ERROR_CODE` output 2: bit0 = parity error, bit1 = stop-bit error, for the last byte.
- `BYTE_READY` output 1: one-cycle pulse when `BYTE_READ`/`BYTE_ERROR_CODE` are updated.

## Operation
- Synchronisers
  - Both pins pass through 2-flop synchronisers (`clk_s`, `dat_s`); reset value 1.
  - `clk_d` is a registered copy of `clk_s`.
  - `fall` = `clk_d & ~clk_s`. All sampling uses `dat_s` in the cycle where `fall` is high.
- Frame format: start (0), 8 data bits LSB first, odd parity, stop (1). 11 falling edges per frame.
- State machine:
  - IDLE: on `fall` with `dat_s`=0 and `READ_ENABLE`=1, clear the bit counter and go to DATA. On `fall` with `dat_s`=1, or with `READ_ENABLE`=0, stay in IDLE and ignore the edge.
  - DATA: on each `fall`, shift `dat_s` into the MSB of an 8-bit shift register (so LSB-first ends aligned) and increment the 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, load `BYTE_READ` from the shift register and set `BYTE_ERROR_CODE` = {~`dat_s`, ~(^{shift, parity})}. Pulse `BYTE_READY` and go to IDLE.
- Errors do not suppress delivery: the byte is always presented with its error code. The consumer decides what to do.
- `READ_ENABLE` is checked only at the start bit. Deasserting it mid-frame does not abort the frame, and the frame still completes with a pulse.
- Timeout:
  - A counter clears on every `fall` and in IDLE, and otherwise increments while in DATA, PARITY or STOP.
  - When it reaches `TIMEOUT`, return to IDLE with no `BYTE_READY` pulse. `BYTE_READ`/`BYTE_ERROR_CODE` are unchanged.
  - Counter width is clog2(`TIMEOUT`+1). It saturates (never wraps).
- `BYTE_READ` and `BYTE_ERROR_CODE` hold their values until the next completed frame.

## Timing
- Reset (async, immediate):
  - State = IDLE; shift register, counters and parity are cleared.
  - `BYTE_READ`=0x00, `BYTE_ERROR_CODE`=2'b00, `BYTE_READY`=0.
  - Synchroniser flops and `clk_d` = 1.
- Reset mid-frame discards the partial frame. The first frame after release is received normally.
- Pin falling edge to `fall` high: 2–3 CLK cycles (synchroniser). The action on `fall` is registered at the following edge.
- `BYTE_READY` goes high in the same cycle that the new `BYTE_READ`/`BYTE_ERROR_CODE` first appear. It is high for exactly 1 cycle per frame.
- The next start bit is accepted on the first `fall` after returning to IDLE. There is no dead time beyond the one-cycle STOP→IDLE transition.
- Rising PS/2 clock edges are ignored. `fall` cannot recur within fewer than 2 CLK cycles.
- Timeout fires exactly `TIMEOUT` cycles after the last `fall` in a non-IDLE state.

## Test plan
- **Good frame, 0xFA:** `READ_ENABLE`=1; send 0xFA with parity=1, stop=1 at a 80 µs PS/2 period. Expect a single `BYTE_READY` pulse with `BYTE_READ`=0xFA and `BYTE_ERROR_CODE`=00. Repeat back-to-back with 0xAA then 0x00; expect three pulses in order.
- **Parity error:** send 0x01 with parity=1 (should be 0). Expect `BYTE_READ`=0x01, `BYTE_ERROR_CODE`=01, one pulse.
- **Stop error:** send 0x03 with parity=1, stop=0. Expect `BYTE_ERROR_CODE`=10 and `BYTE_READ`=0x03.
- **Disabled:** `READ_ENABLE`=0; send 0xFA. Expect no pulse and outputs unchanged. Then drop `READ_ENABLE` mid-frame of a frame started while it was 1; expect that frame delivered.
- **Timeout:** start, 4 data bits, then stall 1.5 ms. Expect no pulse and a return to IDLE. A following frame with 0x00 is then received correctly, with `BYTE_READ`=0x00 and error 00.
- **Reset mid-frame:** assert `RESET` after 6 data bits, without a clock edge. Outputs clear immediately. After release, a 0xF4 frame (parity=0) is delivered with error 00.
